dm_sort_checker: RTL and testbench

//  Hardware readback checker for the single-cycle CPU's data memory. Watches the CPU PC; when it

---
 rtl/cpu_chk_pkg.sv | 24 ++
 rtl/dm_sort_checker.sv | 145 ++++++++++++++
 tb/tb_dm_sort_checker.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_chk_pkg.sv
// Shared types and helpers for the data-memory sort checker.
package cpu_chk_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } chk_state_e;

   localparam int unsigned WORD_BYTES = 4;
   localparam int unsigned WORD_W     = 32;

   // Strict less-than in the chosen number system (signed matches slt).
   function automatic logic lt_word(input logic [WORD_W-1:0] a,
                                    input logic [WORD_W-1:0] b,
                                    input logic              signed_cmp);
      if (signed_cmp) begin
         return $signed(a) < $signed(b);
      end
      return a < b;
   endfunction

endpackage

// File: rtl/dm_sort_checker.sv
// Waits for the CPU to reach HALT_PC, then reads back the array in data memory
// one word at a time and reports whether it is strictly ascending.
module dm_sort_checker
   import cpu_chk_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'd512,
   parameter int unsigned NUM_WORDS  = 12,
   parameter logic [31:0] HALT_PC    = 32'd96,
   parameter int unsigned MAX_CYCLES = 100000,
   parameter bit          SIGNED_CMP = 1'b1
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   input  logic [31:0] rd_data,
   input  logic        rd_valid,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [7:0]  fail_index,
   output logic [31:0] cycle_count
);

   localparam int unsigned      IDX_W     = $clog2(NUM_WORDS) + 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_WORDS - 1);
   localparam logic [31:0]      CYC_LIMIT = 32'(MAX_CYCLES - 1);

   chk_state_e        state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       prev_q, prev_d;
   logic [31:0]       cnt_d;
   logic [31:0]       addr_d;
   logic              rd_req_d, busy_d, done_d, pass_d, timeout_d;
   logic [7:0]        fail_d;
   logic [31:0]       next_addr;

   // Address of the word after the current one; wraps modulo 2^32.
   assign next_addr = BASE_ADDR + (32'(idx_q) + 32'd1) * 32'(WORD_BYTES);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      prev_d    = prev_q;
      cnt_d     = cycle_count;
      addr_d    = rd_addr;
      rd_req_d  = 1'b0;
      busy_d    = busy;
      done_d    = done;
      pass_d    = pass;
      timeout_d = timeout;
      fail_d    = fail_index;

      case (state_q)
         RUN: begin
            if (pc == HALT_PC) begin
               idx_d    = '0;
               rd_req_d = 1'b1;
               addr_d   = BASE_ADDR;
               busy_d   = 1'b1;
               state_d  = REQ;
            end else begin
               if (cycle_count != '1) begin
                  cnt_d = cycle_count + 32'd1;
               end
               if (cycle_count == CYC_LIMIT) begin
                  timeout_d = 1'b1;
                  done_d    = 1'b1;
                  pass_d    = 1'b0;
                  state_d   = DONE;
               end
            end
         end

         REQ: begin
            state_d = WAIT;
         end

         WAIT: begin
            if (rd_valid) begin
               if ((idx_q != '0) && !lt_word(prev_q, rd_data, SIGNED_CMP)) begin
                  fail_d  = 8'(idx_q);
                  pass_d  = 1'b0;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = DONE;
               end else begin
                  prev_d = rd_data;
                  if (idx_q == LAST_IDX) begin
                     pass_d  = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = DONE;
                  end else begin
                     idx_d    = idx_q + IDX_W'(1);
                     rd_req_d = 1'b1;
                     addr_d   = next_addr;
                     state_d  = REQ;
                  end
               end
            end
         end

         DONE: begin
            state_d = DONE;
         end

         default: begin
            state_d = RUN;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RUN;
         idx_q       <= '0;
         prev_q      <= '0;
         cycle_count <= '0;
         rd_req      <= 1'b0;
         rd_addr     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         timeout     <= 1'b0;
         fail_index  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         prev_q      <= prev_d;
         cycle_count <= cnt_d;
         rd_req      <= rd_req_d;
         rd_addr     <= addr_d;
         busy        <= busy_d;
         done        <= done_d;
         pass        <= pass_d;
         timeout     <= timeout_d;
         fail_index  <= fail_d;
      end
   end

endmodule

// File: tb/tb_dm_sort_checker.sv
// Scoreboard bench: two checkers (signed/long limit, unsigned/short limit) each
// with a behavioural memory of programmable read latency.
module tb_dm_sort_checker;

   localparam int NW       = 12;
   localparam int BASE_IDX = 128;

   typedef struct {
      bit pass;
      bit tmo;
      int fidx;
      int cyc;
      int reads;
   } exp_t;

   logic        clk;
   logic        rst_v [2];
   logic [31:0] pc_v  [2];
   logic [1:0]  done_v;
   logic [31:0] mem   [256];
   int          lat;
   int          n_checks;
   int          n_fail;
   exp_t        exp_q0 [$];
   exp_t        exp_q1 [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit less(input logic [31:0] a, input logic [31:0] b, input bit sgn);
      return sgn ? ($signed(a) < $signed(b)) : (a < b);
   endfunction

   // Reference: locate the first word not strictly above its predecessor.
   function automatic exp_t model(input bit sgn, input int maxc, input int n_pre);
      exp_t e;
      e.pass = 1'b0; e.tmo = 1'b0; e.fidx = 0; e.cyc = 0; e.reads = 0;
      if (n_pre < 0 || n_pre >= maxc) begin
         e.tmo = 1'b1;
         e.cyc = maxc;
         return e;
      end
      e.cyc   = n_pre;
      e.pass  = 1'b1;
      e.reads = NW;
      for (int i = 1; i < NW; i++) begin
         if (!less(mem[BASE_IDX+i-1], mem[BASE_IDX+i], sgn)) begin
            e.pass  = 1'b0;
            e.fidx  = i;
            e.reads = i + 1;
            break;
         end
      end
      return e;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        rd_req, rd_valid, busy, done, pass, timeout;
      logic [31:0] rd_addr, rd_data, cycle_count;
      logic [7:0]  fail_index;

      dm_sort_checker #(
         .BASE_ADDR (32'd512),
         .NUM_WORDS (NW),
         .HALT_PC   (32'd96),
         .MAX_CYCLES(g == 0 ? 100000 : 50),
         .SIGNED_CMP(g == 0)
      ) dut (
         .clk        (clk),
         .rst        (rst_v[g]),
         .pc         (pc_v[g]),
         .rd_req     (rd_req),
         .rd_addr    (rd_addr),
         .rd_data    (rd_data),
         .rd_valid   (rd_valid),
         .busy       (busy),
         .done       (done),
         .pass       (pass),
         .timeout    (timeout),
         .fail_index (fail_index),
         .cycle_count(cycle_count)
      );

      assign done_v[g] = done;

      // Memory responder: one strobe lat cycles after the request.
      initial begin : resp
         logic [31:0] a;
         rd_valid = 1'b0;
         rd_data  = '0;
         forever begin
            @(negedge clk);
            if (rd_req) begin
               a = rd_addr;
               repeat (lat) @(posedge clk);
               #1;
               rd_valid = 1'b1;
               rd_data  = mem[a[9:2]];
               @(posedge clk);
               #1;
               rd_valid = 1'b0;
               rd_data  = $urandom;
            end
         end
      end

      // Monitor: reset values, request addresses, and result on done.
      initial begin : mon
         bit   rst_prev;
         bit   seen;
         int   nreads;
         exp_t e;
         rst_prev = 1'b0;
         seen     = 1'b0;
         nreads   = 0;
         forever begin
            @(negedge clk);
            if (rst_prev) begin
               chk("rst_flags", 64'({busy, done, pass, timeout, rd_req, fail_index}), 64'd0);
               chk("rst_cycle_count", 64'(cycle_count), 64'd0);
               chk("rst_rd_addr", 64'(rd_addr), 64'd0);
               nreads = 0;
               seen   = 1'b0;
            end else begin
               if (rd_req) begin
                  chk("rd_addr", 64'(rd_addr), 64'(512 + 4 * nreads));
                  nreads++;
               end
               if (done && !seen) begin
                  seen = 1'b1;
                  if ((g == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_done: dut %0d got done=1 expected no result", g);
                  end else begin
                     if (g == 0) e = exp_q0.pop_front();
                     else        e = exp_q1.pop_front();
                     chk("pass", 64'(pass), 64'(e.pass));
                     chk("timeout", 64'(timeout), 64'(e.tmo));
                     chk("fail_index", 64'(fail_index), 64'(e.fidx));
                     chk("cycle_count", 64'(cycle_count), 64'(e.cyc));
                     chk("read_count", 64'(nreads), 64'(e.reads));
                     chk("busy_at_done", 64'(busy), 64'd0);
                  end
               end
            end
            rst_prev = rst_v[g];
         end
      end
   end

   task automatic load_ramp();
      for (int i = 0; i < NW; i++) mem[BASE_IDX+i] = 32'(11 * i);
   endtask

   // Reset one checker, release it, hold pc off HALT for n_pre cycles (n_pre<0: forever).
   task automatic run(input int g, input int n_pre);
      exp_t e;
      bit   got;
      rst_v[g] = 1'b1;
      pc_v[g]  = 32'd0;
      @(posedge clk);
      #1;
      rst_v[g] = 1'b0;
      e = model(g == 0, g == 0 ? 100000 : 50, n_pre);
      if (g == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
      got = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (done_v[g]) begin
            got = 1'b1;
            break;
         end
         if (n_pre >= 0 && c >= n_pre) pc_v[g] = 32'd96;
         else                          pc_v[g] = 32'($urandom_range(0, 23)) * 32'd4;
         @(posedge clk);
         #1;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL done_wait: dut %0d got no done expected done within budget", g);
         if (g == 0) exp_q0.delete();
         else        exp_q1.delete();
      end
      for (int c = 0; c < 2; c++) begin
         pc_v[g] = 32'($urandom_range(0, 40)) * 32'd4;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bit got;
      n_checks = 0;
      n_fail   = 0;
      lat      = 1;
      rst_v[0] = 1'b1; rst_v[1] = 1'b1;
      pc_v[0]  = 32'd0; pc_v[1] = 32'd0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (3) @(posedge clk);
      #1;

      // Sorted ramp, both compare modes, both latencies.
      load_ramp();
      run(0, 40);
      run(1, 40);
      lat = 3;
      run(0, 17);

      // Unsorted CPU image.
      mem[128] = 32'd55;  mem[129] = 32'd88;  mem[130] = 32'd0;   mem[131] = 32'd22;
      mem[132] = 32'd11;  mem[133] = 32'd99;  mem[134] = 32'd33;  mem[135] = 32'd77;
      mem[136] = 32'd66;  mem[137] = 32'd121; mem[138] = 32'd110; mem[139] = 32'd44;
      lat = 1;
      run(0, 10);
      lat = 3;
      run(1, 5);

      // Equal neighbours.
      lat = 1;
      load_ramp();
      mem[130] = 32'd22;
      mem[131] = 32'd22;
      run(0, 8);

      // Negative first word: ordered when signed, not when unsigned.
      mem[128] = 32'hFFFF_FFFF;
      for (int i = 1; i < NW; i++) mem[BASE_IDX+i] = 32'(i - 1);
      run(0, 12);
      run(1, 12);

      // Never halts: short-limit checker times out.
      load_ramp();
      run(1, -1);
      run(1, 49);

      // Reset inside WAIT with a slow memory; stray strobe lands in RUN.
      lat = 3;
      rst_v[0] = 1'b1;
      pc_v[0]  = 32'd0;
      @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      pc_v[0]  = 32'd96;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         #1;
         if (g_dut[0].rd_req) begin
            got = 1'b1;
            break;
         end
      end
      chk("t6_req_seen", 64'(got), 64'd1);
      pc_v[0] = 32'd0;
      @(posedge clk);
      #1;
      rst_v[0] = 1'b1;
      @(posedge clk);
      #1;
      rst_v[0] = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("t6_flags_after_stray",
          64'({g_dut[0].busy, g_dut[0].done, g_dut[0].pass, g_dut[0].timeout, g_dut[0].fail_index}),
          64'd0);
      chk("t6_cycle_count", 64'(g_dut[0].cycle_count), 64'd6);
      load_ramp();
      run(0, 4);

      // Randomised arrays, latencies, instances and halt times.
      for (int t = 0; t < 10; t++) begin
         int g;
         int v;
         g = int'($urandom_range(0, 1));
         lat = int'($urandom_range(1, 3));
         v = int'($urandom_range(0, 1000)) - 500;
         for (int i = 0; i < NW; i++) begin
            mem[BASE_IDX+i] = 32'(v);
            v += int'($urandom_range(1, 40));
         end
         if ($urandom_range(0, 1) == 1) begin
            int j;
            j = int'($urandom_range(1, NW - 1));
            mem[BASE_IDX+j] = mem[BASE_IDX+j-1] - 32'($urandom_range(0, 3));
         end
         run(g, int'($urandom_range(0, 60)));
      end

      repeat (3) @(posedge clk);
      #1;
      if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL leftover_expect: got %0d pending expected 0", exp_q0.size() + exp_q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
